// File: rtl/sobel_magnitude_if.sv
// Stream interface for sobel_magnitude: gradient pairs in, thresholded magnitude out.
// Signal names keep the block's port naming so both sides read the same.
interface sobel_magnitude_if #(
  parameter int WIDTH_P = 8
);
  logic                          valid_i;
  logic                          ready_o;
  logic signed [2*WIDTH_P-1:0]   gx_i;
  logic signed [2*WIDTH_P-1:0]   gy_i;
  logic        [WIDTH_P-1:0]     thresh_i;
  logic                          valid_o;
  logic                          ready_i;
  logic        [WIDTH_P-1:0]     mag_o;
  logic                          edge_o;
  logic                          eol_o;
  logic                          eof_o;

  modport master (
    output valid_i, gx_i, gy_i, thresh_i, ready_i,
    input  ready_o, valid_o, mag_o, edge_o, eol_o, eof_o
  );

  modport slave (
    input  valid_i, gx_i, gy_i, thresh_i, ready_i,
    output ready_o, valid_o, mag_o, edge_o, eol_o, eof_o
  );
endinterface

// File: rtl/sobel_magnitude.sv
// Two-stage elastic pipeline: |gx|+|gy| magnitude with saturation, border masking,
// edge threshold and end-of-line / end-of-frame tagging.
module sobel_magnitude #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input logic            clk_i,
  input logic            rstn_i,
  sobel_magnitude_if.slave bus
);
  localparam int GW = 2 * WIDTH_P;
  localparam int AW = GW - 1;
  localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);

  // Negating the most-negative value wraps back to negative; clamp it instead.
  function automatic logic [AW-1:0] abs_sat(input logic signed [GW-1:0] v);
    logic signed [GW-1:0] neg;
    logic        [AW-1:0] res;
    neg = -v;
    if (!v[GW-1])
      res = v[AW-1:0];
    else if (neg[GW-1])
      res = '1;
    else
      res = neg[AW-1:0];
    return res;
  endfunction

  function automatic logic [WIDTH_P-1:0] mag_sat(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [GW-1:0]      sum;
    logic [WIDTH_P-1:0] res;
    sum = {1'b0, a} + {1'b0, b};
    if (|sum[GW-1:WIDTH_P])
      res = '1;
    else
      res = sum[WIDTH_P-1:0];
    return res;
  endfunction

  logic               vld_p1;
  logic [AW-1:0]      ax_p1;
  logic [AW-1:0]      ay_p1;
  logic [WIDTH_P-1:0] thr_p1;
  logic               mask_p1;
  logic               eol_p1;
  logic               eof_p1;

  logic               vld_p2;
  logic [WIDTH_P-1:0] mag_p2;
  logic               edge_p2;
  logic               eol_p2;
  logic               eof_p2;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;

  logic               load2;
  logic               ready;
  logic               accept;
  logic               border;
  logic [WIDTH_P-1:0] mag_w;

  assign load2  = !vld_p2 || bus.ready_i;
  assign ready  = !vld_p1 || load2;
  assign accept = bus.valid_i && ready;
  assign border = (col <= CW'(1)) || (row <= RW'(1));
  assign mag_w  = mag_sat(ax_p1, ay_p1);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else begin
      if (ready) vld_p1 <= bus.valid_i;
      if (load2) vld_p2 <= vld_p1;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage 1: absolute gradients plus position flags and threshold of this pixel
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ax_p1   <= abs_sat(bus.gx_i);
      ay_p1   <= abs_sat(bus.gy_i);
      thr_p1  <= bus.thresh_i;
      mask_p1 <= border;
      eol_p1  <= (col == COL_LAST);
      eof_p1  <= (col == COL_LAST) && (row == ROW_LAST);
    end
  end

  // Stage 2: saturated magnitude and edge decision; holds while downstream stalls
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mag_p2  <= '0;
      edge_p2 <= 1'b0;
      eol_p2  <= 1'b0;
      eof_p2  <= 1'b0;
    end else if (load2 && vld_p1) begin
      mag_p2  <= mask_p1 ? '0 : mag_w;
      edge_p2 <= !mask_p1 && (mag_w >= thr_p1);
      eol_p2  <= eol_p1;
      eof_p2  <= eof_p1;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = vld_p2;
  assign bus.mag_o   = mag_p2;
  assign bus.edge_o  = edge_p2;
  assign bus.eol_o   = eol_p2;
  assign bus.eof_o   = eof_p2;
endmodule

// File: tb/tb_sobel_magnitude.sv
// Bench for sobel_magnitude: table vectors, directed stall/reset sequences and
// randomized handshakes scored against a position-based reference model.
module tb_sobel_magnitude;
  localparam int W = 8;
  localparam int D = 16;
  localparam int H = 16;

  typedef struct {
    int mag;
    int edg;
    int eol;
    int eof;
  } exp_t;

  typedef struct {
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic [7:0]         th;
    int                 mag;
    int                 edg;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sobel_magnitude_if #(.WIDTH_P(W)) bus ();

  sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];
  int   pos = 0;
  int   cyc_n = 0;
  int   acc_cnt, out_cnt, eof_cnt, eol_cnt, eof_at, first_acc, first_vld;
  logic held = 1'b0;
  int   snap;
  logic use_tab = 1'b0;
  int   tab_mag, tab_edg;
  vec_t tab[10];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference: pixel position comes from the accept count, magnitude from plain integers.
  function automatic exp_t model(input logic signed [15:0] gx, input logic signed [15:0] gy,
                                 input logic [7:0] th, input int p);
    exp_t e;
    int c, r, ax, ay, s;
    c  = p % D;
    r  = p / D;
    ax = (gx < 0) ? -int'(gx) : int'(gx);
    ay = (gy < 0) ? -int'(gy) : int'(gy);
    if (ax > 32767) ax = 32767;
    if (ay > 32767) ay = 32767;
    s     = ax + ay;
    e.mag = (s > 255) ? 255 : s;
    e.edg = (e.mag >= int'(th)) ? 1 : 0;
    if (c < 2 || r < 2) begin
      e.mag = 0;
      e.edg = 0;
    end
    e.eol = (c == D - 1) ? 1 : 0;
    e.eof = (c == D - 1 && r == H - 1) ? 1 : 0;
    return e;
  endfunction

  function automatic int packed_out();
    return {21'd0, bus.mag_o, bus.edge_o, bus.eol_o, bus.eof_o};
  endfunction

  task automatic cyc(input logic v, input logic signed [15:0] gx, input logic signed [15:0] gy,
                     input logic [7:0] th, input logic rdy);
    exp_t e;
    @(negedge clk);
    bus.valid_i  = v;
    bus.gx_i     = gx;
    bus.gy_i     = gy;
    bus.thresh_i = th;
    bus.ready_i  = rdy;
    #1;
    cyc_n++;
    if (rstn) begin
      if (bus.valid_o) begin
        if (first_vld < 0) first_vld = cyc_n;
        if (held) check("stall_hold", packed_out(), snap);
        if (bus.ready_i) begin
          held = 1'b0;
          if (q.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = q.pop_front();
            out_cnt++;
            check("out_mag", int'(bus.mag_o), e.mag);
            check("out_edge", int'(bus.edge_o), e.edg);
            check("out_eol", int'(bus.eol_o), e.eol);
            check("out_eof", int'(bus.eof_o), e.eof);
            if (bus.eol_o) eol_cnt++;
            if (bus.eof_o) begin
              eof_cnt++;
              if (eof_at < 0) eof_at = out_cnt;
            end
          end
        end else begin
          held = 1'b1;
          snap = packed_out();
        end
      end else begin
        if (held) check("stall_valid_dropped", 0, 1);
        held = 1'b0;
      end
      if (bus.valid_i && bus.ready_o) begin
        e = model(gx, gy, th, pos);
        if (use_tab) begin
          e.mag = tab_mag;
          e.edg = tab_edg;
        end
        q.push_back(e);
        pos = (pos + 1) % (D * H);
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc_n;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b1;
    bus.gx_i     = '0;
    bus.gy_i     = '0;
    bus.thresh_i = '0;
    q.delete();
    pos  = 0;
    held = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid_o", int'(bus.valid_o), 0);
    check("rst_outputs", packed_out(), 0);
    acc_cnt = 0; out_cnt = 0; eof_cnt = 0; eol_cnt = 0;
    eof_at = -1; first_acc = -1; first_vld = -1;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("ready_after_rst", int'(bus.ready_o), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) cyc(1'b0, 16'sd0, 16'sd0, 8'd0, 1'b1);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int a0, idle_vld, guard;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.gx_i     = '0;
    bus.gy_i     = '0;
    bus.thresh_i = '0;

    tab[0] = '{16'sd200,    16'sd200,    8'd255, 255, 1};
    tab[1] = '{-16'sd32768, 16'sd0,      8'd0,   255, 1};
    tab[2] = '{16'sd10,     -16'sd5,     8'd16,  15,  0};
    tab[3] = '{16'sd10,     -16'sd5,     8'd15,  15,  1};
    tab[4] = '{16'sd30,     -16'sd20,    8'd40,  50,  1};
    tab[5] = '{16'sd0,      16'sd0,      8'd0,   0,   1};
    tab[6] = '{-16'sd128,   16'sd127,    8'd255, 255, 1};
    tab[7] = '{-16'sd100,   -16'sd100,   8'd201, 200, 0};
    tab[8] = '{16'sd32767,  -16'sd32768, 8'd0,   255, 1};
    tab[9] = '{-16'sd1,     16'sd0,      8'd2,   1,   0};

    // Full-rate frame of a constant gradient
    do_reset();
    for (int i = 0; i < 256; i++) cyc(1'b1, 16'sd30, -16'sd20, 8'd40, 1'b1);
    check("stream_accepts", acc_cnt, 256);
    drain();
    check("stream_outputs", out_cnt, 256);
    check("latency", first_vld - first_acc, 2);
    check("stream_eof_at", eof_at, 256);

    // Table vectors, each placed on an unmasked pixel
    for (int k = 0; k < 10; k++) begin
      guard = 0;
      while (((pos % D) < 2 || (pos / D) < 2) && guard < 64) begin
        cyc(1'b1, 16'sd0, 16'sd0, 8'd0, 1'b1);
        guard++;
      end
      use_tab = 1'b1;
      tab_mag = tab[k].mag;
      tab_edg = tab[k].edg;
      cyc(1'b1, tab[k].gx, tab[k].gy, tab[k].th, 1'b1);
      use_tab = 1'b0;
    end
    drain();

    // Downstream stall: only two pairs fit, then full rate resumes
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 16'(signed'($urandom)), 16'(signed'($urandom)), 8'($urandom), 1'b0);
    check("stall_accepts", acc_cnt - a0, 2);
    check("stall_ready_o", int'(bus.ready_o), 0);
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 16'(signed'($urandom)), 16'(signed'($urandom)), 8'($urandom), 1'b1);
    check("resume_accepts", acc_cnt - a0, 10);
    drain();

    // Random handshakes over two frames
    do_reset();
    for (int i = 0; i < 6000 && acc_cnt < 512; i++)
      cyc(($urandom_range(0, 1) == 1) && (acc_cnt < 511 || 1'b1),
          16'(signed'($urandom_range(0, 1023) - 512)), 16'(signed'($urandom_range(0, 1023) - 512)),
          8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3 && acc_cnt > 512; i++) check("rand_overrun", acc_cnt, 512);
    for (int i = 0; i < 80 && q.size() > 0; i++)
      cyc(1'b0, 16'sd0, 16'sd0, 8'd0, 1'($urandom_range(0, 1)));
    drain();
    check("rand_outputs", out_cnt, acc_cnt);
    check("rand_eol_cnt", eol_cnt, acc_cnt / D);
    check("rand_eof_at", eof_at, 256);
    check("rand_eof_cnt", eof_cnt, acc_cnt / (D * H));

    // Reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 400 && acc_cnt < 37; i++)
      cyc(1'b1, 16'(signed'($urandom)), 16'(signed'($urandom)), 8'($urandom), 1'($urandom_range(0, 1)));
    check("pre_rst_accepts", acc_cnt, 37);
    do_reset();
    idle_vld = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'sd0, 16'sd0, 8'd0, 1'b1);
      if (bus.valid_o) idle_vld++;
    end
    check("no_stale_valid", idle_vld, 0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 16'sd30, -16'sd20, 8'd40, 1'b1);
    drain();
    check("post_rst_outputs", out_cnt, 256);
    check("post_rst_eof_at", eof_at, 256);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
